y86_mem_arbiter: RTL and testbench
==================================

Name: y86_mem_arbiter

Overview:
- Shares one single-port, fixed-latency backing memory between the pipelined Y86-64 core's instruction-fetch port and its data-memory port.
- Arbitrates between the two ports, sequences each access, and returns response and error status. Error status feeds the imem_error/dmem_error paths that drive stat.
- Sits between the fetch/memory stages and the memory array.
- At most one transaction is outstanding at any time.

Parameters:
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (1..15)
MAX_STREAK, 3, consecutive data grants allowed while fetch is pending before fetch is forced
ADDR_LIMIT, 64'h0000_0000_0000_1000, first illegal byte address; addr >= ADDR_LIMIT is an error

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  64  fetch byte address
if_gnt  out  1  one-cycle grant pulse for fetch
if_rvalid  out  1  one-cycle fetch response valid
if_rdata  out  64  fetch read data
if_err  out  1  fetch address error, qualified by if_rvalid
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt
dm_we  in  1  1 = write, 0 = read
dm_addr  in  64  data byte address
dm_wdata  in  64  write data
dm_gnt  out  1  one-cycle grant pulse for data
dm_rvalid  out  1  one-cycle data response/ack
dm_rdata  out  64  data read data (0 for writes)
dm_err  out  1  data address error, qualified by dm_rvalid
mem_en  out  1  backing memory access strobe, one cycle
mem_we  out  1  backing memory write enable
mem_addr  out  64  backing memory address
mem_wdata  out  64  backing memory write data
mem_rdata  in  64  backing memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low.
- Outputs: all outputs are registered.
- Reset values: state IDLE, streak counter 0, latency counter 0, every output 0.
- Reset mid-operation: the outstanding transaction is abandoned and no rvalid is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE and RESP, arbitration on each rising edge:
  - Data wins over fetch, unless streak == MAX_STREAK and if_req is high; then fetch wins.
  - The winner's gnt is asserted the next cycle (cycle T).
  - The request fields are captured at the same edge.
- Address legal:
  - mem_en=1 in cycle T, with mem_we/mem_addr/mem_wdata taken from the captured request.
  - State goes to WAIT with counter = MEM_LAT.
- Address illegal (addr >= ADDR_LIMIT):
  - No mem_en.
  - State goes to RESP, with rvalid=1, err=1 and rdata=0 in cycle T+1.
- WAIT: the counter decrements each cycle.
  - When it reaches 0 (cycle T+MEM_LAT), mem_rdata is latched.
  - State goes to RESP.
- RESP: the matching rvalid is high for exactly one cycle (T+MEM_LAT+1) with err=0.
  - Read: rdata = latched mem_rdata.
  - Write: rdata = 0.
  - Arbitration happens in the same cycle, so the next gnt can fall at T+MEM_LAT+2.
  - Legal access occupancy = MEM_LAT+2 cycles.
- Streak counter:
  - Increments on a data grant when if_req is high at that edge, saturating at MAX_STREAK.
  - Clears on any fetch grant.
  - Clears on a data grant when if_req is low.
- Grant rules:
  - gnt is never asserted for a port whose req is low at the arbitration edge.
  - A requester may drop req only after its gnt.
- Simultaneous requests with streak < MAX_STREAK: data is granted and fetch waits.
- Response data rules:
  - rdata holds its value between responses.
  - The rvalid/err of the non-granted port stays 0.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds output if_stall_cnt[31:0]: increments each cycle if_req is high and if_gnt is low.
  - Adds output dm_gnt_cnt[31:0]: increments on each dm_gnt.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package y86_mem_pkg holds:
  - FSM state encoding (IDLE/WAIT/RESP).
  - Port-select encoding (SEL_IF, SEL_DM).
  - Default ADDR_LIMIT and word width (64).
- Sub-module y86_arb_pick (combinational priority/starvation selector):
  - Inputs: if_req, dm_req, streak.
  - Output: sel, valid.
- Everything else is in the top module.

Test Plan:
- Single fetch with MEM_LAT=2: if_req, if_addr=0x10, mem model returns 0x30F4000000000000.
  - Required: if_gnt at T, mem_en at T, if_rvalid at T+3 with if_rdata=0x30F4000000000000 and if_err=0.
- Simultaneous requests: if_req and dm_req (read 0x200) both high from cycle 0.
  - Required: dm_gnt first; if_gnt at the next arbitration, MEM_LAT+2 cycles after dm_gnt.
- Starvation: dm_req held high for 10 transactions while if_req is held high, MAX_STREAK=3.
  - Required: grant order DM,DM,DM,IF,DM,DM,DM,IF,...
- Address error: dm write to 0x1000 with ADDR_LIMIT=0x1000.
  - Required: no mem_en, dm_rvalid with dm_err=1 and dm_rdata=0 one cycle after dm_gnt.
- Write then read: write 0xDEADBEEF to 0x80, then read 0x80.
  - Required: write ack has rdata=0; read returns 0xDEADBEEF.
  - mem_we=1 only during the write's mem_en cycle.
- Reset mid-WAIT: deassert reset_n one cycle after mem_en.
  - Required: all outputs 0 immediately (asynchronous); no rvalid after release; a new request after release is granted normally.

Source files
------------

// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86-64 fetch/data memory arbiter.
package y86_mem_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned CNT_W  = 4;
    localparam logic [WORD_W-1:0] DEF_ADDR_LIMIT = 64'h0000_0000_0000_1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        SEL_IF = 1'b0,
        SEL_DM = 1'b1
    } port_sel_e;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    function automatic logic addr_illegal(input logic [WORD_W-1:0] addr,
                                          input logic [WORD_W-1:0] limit);
        return addr >= limit;
    endfunction

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Fetch, data and backing-memory signal bundle for y86_mem_arbiter.
interface y86_mem_arbiter_if;
    import y86_mem_pkg::*;

    logic              if_req;
    logic [WORD_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [WORD_W-1:0] if_rdata;
    logic              if_err;

    logic              dm_req;
    logic              dm_we;
    logic [WORD_W-1:0] dm_addr;
    logic [WORD_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [WORD_W-1:0] dm_rdata;
    logic              dm_err;

    logic              mem_en;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output dm_gnt, dm_rvalid, dm_rdata, dm_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/y86_arb_pick.sv
// Combinational port selector: data has priority unless fetch has been
// passed over MAX_STREAK times in a row.
module y86_arb_pick
    import y86_mem_pkg::*;
#(
    parameter int unsigned STREAK_W   = 2,
    parameter int unsigned MAX_STREAK = 3
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic [STREAK_W-1:0] streak,
    output port_sel_e           sel,
    output logic                valid
);

    logic force_if;

    always_comb begin
        force_if = if_req && (streak == STREAK_W'(MAX_STREAK));
        valid    = if_req || dm_req;
        sel      = (if_req && (!dm_req || force_if)) ? SEL_IF : SEL_DM;
    end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Shares one fixed-latency memory between the Y86-64 fetch and data ports.
// Optional ARB_PERF_CNT_EN adds fetch-stall and data-grant counters.
module y86_mem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int unsigned       MEM_LAT    = 2,
    parameter int unsigned       MAX_STREAK = 3,
    parameter logic [WORD_W-1:0] ADDR_LIMIT = DEF_ADDR_LIMIT
) (
    input  logic clock,
    input  logic reset_n,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0] if_stall_cnt,
    output logic [31:0] dm_gnt_cnt,
`endif
    y86_mem_arbiter_if.slave bus
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    port_sel_e           cur_sel_q, cur_sel_d;
    logic                cur_we_q, cur_we_d;
    logic                cur_err_q, cur_err_d;

    logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
    logic              if_err_q, if_err_d, dm_err_q, dm_err_d;
    logic [WORD_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

    port_sel_e         pick_sel;
    logic              pick_valid;
    mem_req_t          win_req;
    logic              win_bad;
    logic [WORD_W-1:0] rsp_data;

    y86_arb_pick #(
        .STREAK_W  (STREAK_W),
        .MAX_STREAK(MAX_STREAK)
    ) u_pick (
        .if_req(bus.if_req),
        .dm_req(bus.dm_req),
        .streak(streak_q),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    // Request fields of whichever port wins this edge.
    always_comb begin
        win_req = '0;
        if (pick_sel == SEL_DM) begin
            win_req.we    = bus.dm_we;
            win_req.addr  = bus.dm_addr;
            win_req.wdata = bus.dm_wdata;
        end else begin
            win_req.addr  = bus.if_addr;
        end
        win_bad = addr_illegal(win_req.addr, ADDR_LIMIT);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        cur_sel_d   = cur_sel_q;
        cur_we_d    = cur_we_q;
        cur_err_d   = cur_err_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_err_d    = 1'b0;
        dm_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_data    = (cur_err_q || cur_we_q) ? '0 : bus.mem_rdata;

        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (pick_valid) begin
                    state_d   = WAIT;
                    cur_sel_d = pick_sel;
                    cur_we_d  = win_req.we;
                    cur_err_d = win_bad;
                    if (pick_sel == SEL_DM) begin
                        dm_gnt_d = 1'b1;
                        if (!bus.if_req) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_W'(MAX_STREAK)) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end else begin
                        if_gnt_d = 1'b1;
                        streak_d = '0;
                    end
                    // An illegal address skips memory; a zero count makes
                    // its error response land one cycle after the grant.
                    if (win_bad) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d       = CNT_W'(MEM_LAT);
                        mem_en_d    = 1'b1;
                        mem_we_d    = win_req.we;
                        mem_addr_d  = win_req.addr;
                        mem_wdata_d = win_req.wdata;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (cur_sel_q == SEL_IF) begin
                        if_rvalid_d = 1'b1;
                        if_err_d    = cur_err_q;
                        if_rdata_d  = rsp_data;
                    end else begin
                        dm_rvalid_d = 1'b1;
                        dm_err_d    = cur_err_q;
                        dm_rdata_d  = rsp_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            cur_sel_q   <= SEL_IF;
            cur_we_q    <= 1'b0;
            cur_err_q   <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            cur_sel_q   <= cur_sel_d;
            cur_we_q    <= cur_we_d;
            cur_err_q   <= cur_err_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_err_q    <= if_err_d;
            dm_err_q    <= dm_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.dm_gnt    = dm_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.if_err    = if_err_q;
    assign bus.dm_err    = dm_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef ARB_PERF_CNT_EN
    // Free-running wrap-around performance counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if_stall_cnt <= '0;
            dm_gnt_cnt   <= '0;
        end else begin
            if (bus.if_req && !if_gnt_q) begin
                if_stall_cnt <= if_stall_cnt + 32'd1;
            end
            if (dm_gnt_q) begin
                dm_gnt_cnt <= dm_gnt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed self-checking bench for y86_mem_arbiter with a 2-cycle memory model.
module tb_y86_mem_arbiter;
    import y86_mem_pkg::*;

    localparam int unsigned LAT    = 2;
    localparam logic [63:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;
    localparam logic [63:0] D10    = 64'h30F4_0000_0000_0000;
    localparam logic [63:0] D18    = 64'h6020_0000_0000_0000;
    localparam logic [63:0] D200   = 64'h0123_4567_89AB_CDEF;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    y86_mem_arbiter_if bus();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt;
    logic [31:0] dm_gnt_cnt;
`endif

    y86_mem_arbiter #(
        .MEM_LAT   (LAT),
        .MAX_STREAK(3),
        .ADDR_LIMIT(64'h0000_0000_0000_1000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
`ifdef ARB_PERF_CNT_EN
        .if_stall_cnt(if_stall_cnt),
        .dm_gnt_cnt  (dm_gnt_cnt),
`endif
        .bus         (bus)
    );

    always #5 clock = ~clock;

    // Backing memory: read data valid only in the cycle LAT cycles after mem_en.
    logic [63:0] mem [0:511];
    logic        pre_en = 1'b0;
    logic [63:0] pre_addr, pre_data;
    logic        pv = 1'b0;
    logic [63:0] pd;

    always @(posedge clock) begin
        if (pre_en) mem[pre_addr[11:3]] <= pre_data;
        else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[11:3]] <= bus.mem_wdata;
        pv            <= bus.mem_en && !bus.mem_we;
        pd            <= mem[bus.mem_addr[11:3]];
        bus.mem_rdata <= pv ? pd : POISON;
    end

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        @(negedge clock);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock);
        pre_en = 1'b0;
    endtask

    task automatic issue_if(input logic [63:0] a, output logic got);
        bus.if_addr = a; bus.if_req = 1'b1; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.if_gnt) begin got = 1'b1; break; end
        end
        bus.if_req = 1'b0;
    endtask

    task automatic issue_dm(input logic we, input logic [63:0] a, input logic [63:0] d,
                            output logic got);
        bus.dm_we = we; bus.dm_addr = a; bus.dm_wdata = d; bus.dm_req = 1'b1; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.dm_gnt) begin got = 1'b1; break; end
        end
        bus.dm_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] ctl;
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = 0; bus.dm_wdata = 0;
        #1 reset_n = 1'b0;
        preload(64'h10, D10);
        preload(64'h18, D18);
        preload(64'h200, D200);
        ctl = {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid,
               bus.if_err, bus.dm_err, bus.mem_en, bus.mem_we};
        checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL reset_ctl: got %b expected 00000000", ctl); end
        checks++; if (bus.if_rdata !== 64'h0) begin errors++; $display("FAIL reset_if_rdata: got %h expected 0", bus.if_rdata); end
        checks++; if (bus.dm_rdata !== 64'h0) begin errors++; $display("FAIL reset_dm_rdata: got %h expected 0", bus.dm_rdata); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 128'h0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);
        checks++; if ({bus.if_gnt, bus.dm_gnt} !== 2'b00) begin errors++; $display("FAIL idle_no_gnt: got %b expected 00", {bus.if_gnt, bus.dm_gnt}); end
    endtask

    task automatic test_single_fetch();
        logic got;
        issue_if(64'h10, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %b expected 1", got); end
        checks++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin errors++; $display("FAIL fetch_mem_en: got en/we %b expected 10", {bus.mem_en, bus.mem_we}); end
        checks++; if (bus.mem_addr !== 64'h10) begin errors++; $display("FAIL fetch_mem_addr: got %h expected 10", bus.mem_addr); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            if (k < 3) begin
                checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_early_rvalid: got %b expected 0 at T+%0d", bus.if_rvalid, k); end
            end
        end
        checks++; if ({bus.if_rvalid, bus.if_err, bus.dm_rvalid} !== 3'b100) begin errors++; $display("FAIL fetch_rvalid: got rvalid/err/dm_rvalid %b expected 100", {bus.if_rvalid, bus.if_err, bus.dm_rvalid}); end
        checks++; if (bus.if_rdata !== D10) begin errors++; $display("FAIL fetch_rdata: got %h expected %h", bus.if_rdata, D10); end
        @(negedge clock);
        checks++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b0, D10}) begin errors++; $display("FAIL fetch_hold: got %b/%h expected 0/%h", bus.if_rvalid, bus.if_rdata, D10); end
    endtask

    task automatic test_simultaneous();
        logic got;
        int   gap;
        bus.if_addr = 64'h18; bus.if_req = 1'b1;
        issue_dm(1'b0, 64'h200, 64'h0, got);
        checks++; if ({got, bus.if_gnt} !== 2'b10) begin errors++; $display("FAIL sim_dm_first: got dm/if %b expected 10", {got, bus.if_gnt}); end
        gap = 0;
        while (gap < 20) begin
            @(negedge clock);
            gap++;
            if (gap == 3) begin
                checks++; if ({bus.dm_rvalid, bus.dm_rdata} !== {1'b1, D200}) begin errors++; $display("FAIL sim_dm_resp: got %b/%h expected 1/%h", bus.dm_rvalid, bus.dm_rdata, D200); end
            end
            if (bus.if_gnt) break;
        end
        bus.if_req = 1'b0;
        checks++; if (gap !== LAT + 2) begin errors++; $display("FAIL sim_if_gap: got %0d expected %0d", gap, LAT + 2); end
        repeat (3) @(negedge clock);
        checks++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, D18}) begin errors++; $display("FAIL sim_if_resp: got %b/%h expected 1/%h", bus.if_rvalid, bus.if_rdata, D18); end
    endtask

    task automatic test_starvation();
        int         g;
        int         cyc;
        logic [1:0] exp;
        bus.if_addr = 64'h18; bus.dm_we = 1'b0; bus.dm_addr = 64'h200;
        bus.if_req = 1'b1; bus.dm_req = 1'b1;
        g = 0; cyc = 0;
        while (g < 13 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (bus.if_gnt || bus.dm_gnt) begin
                exp = ((g % 4) == 3) ? 2'b01 : 2'b10;
                checks++; if ({bus.dm_gnt, bus.if_gnt} !== exp) begin errors++; $display("FAIL starve_order_%0d: got dm/if %b expected %b", g, {bus.dm_gnt, bus.if_gnt}, exp); end
                g++;
            end
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        checks++; if (g !== 13) begin errors++; $display("FAIL starve_count: got %0d grants expected 13", g); end
        repeat (5) @(negedge clock);
    endtask

    task automatic test_addr_error();
        logic got;
        issue_dm(1'b1, 64'h1000, 64'h5555, got);
        checks++; if ({got, bus.mem_en} !== 2'b10) begin errors++; $display("FAIL dm_err_gnt: got gnt/mem_en %b expected 10", {got, bus.mem_en}); end
        @(negedge clock);
        checks++; if ({bus.dm_rvalid, bus.dm_err, bus.if_rvalid, bus.mem_en} !== 4'b1100) begin errors++; $display("FAIL dm_err_resp: got %b expected 1100", {bus.dm_rvalid, bus.dm_err, bus.if_rvalid, bus.mem_en}); end
        checks++; if (bus.dm_rdata !== 64'h0) begin errors++; $display("FAIL dm_err_rdata: got %h expected 0", bus.dm_rdata); end
        @(negedge clock);
        checks++; if ({bus.dm_rvalid, bus.dm_err} !== 2'b00) begin errors++; $display("FAIL dm_err_clear: got %b expected 00", {bus.dm_rvalid, bus.dm_err}); end
        issue_if(64'hFFFF_FFFF_FFFF_FFF8, got);
        checks++; if ({got, bus.mem_en} !== 2'b10) begin errors++; $display("FAIL if_err_gnt: got gnt/mem_en %b expected 10", {got, bus.mem_en}); end
        @(negedge clock);
        checks++; if ({bus.if_rvalid, bus.if_err, bus.dm_rvalid, bus.if_rdata} !== {3'b110, 64'h0}) begin errors++; $display("FAIL if_err_resp: got %b/%h expected 110/0", {bus.if_rvalid, bus.if_err, bus.dm_rvalid}, bus.if_rdata); end
        @(negedge clock);
    endtask

    task automatic test_write_read();
        logic got;
        issue_dm(1'b0, 64'h200, 64'h0, got);
        repeat (3) @(negedge clock);
        checks++; if ({bus.dm_rvalid, bus.dm_rdata} !== {1'b1, D200}) begin errors++; $display("FAIL wr_pre_read: got %b/%h expected 1/%h", bus.dm_rvalid, bus.dm_rdata, D200); end
        issue_dm(1'b1, 64'h80, 64'hDEADBEEF, got);
        checks++; if ({got, bus.mem_en, bus.mem_we} !== 3'b111) begin errors++; $display("FAIL wr_mem_en: got gnt/en/we %b expected 111", {got, bus.mem_en, bus.mem_we}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== {64'h80, 64'hDEADBEEF}) begin errors++; $display("FAIL wr_mem_bus: got %h/%h expected 80/deadbeef", bus.mem_addr, bus.mem_wdata); end
        @(negedge clock);
        checks++; if ({bus.mem_en, bus.mem_we} !== 2'b00) begin errors++; $display("FAIL wr_we_pulse: got en/we %b expected 00", {bus.mem_en, bus.mem_we}); end
        repeat (2) @(negedge clock);
        checks++; if ({bus.dm_rvalid, bus.dm_err, bus.dm_rdata} !== {2'b10, 64'h0}) begin errors++; $display("FAIL wr_ack: got %b/%h expected 10/0", {bus.dm_rvalid, bus.dm_err}, bus.dm_rdata); end
        issue_dm(1'b0, 64'h80, 64'h0, got);
        checks++; if ({got, bus.mem_en, bus.mem_we} !== 3'b110) begin errors++; $display("FAIL rd_mem_en: got gnt/en/we %b expected 110", {got, bus.mem_en, bus.mem_we}); end
        repeat (3) @(negedge clock);
        checks++; if ({bus.dm_rvalid, bus.dm_rdata} !== {1'b1, 64'hDEADBEEF}) begin errors++; $display("FAIL rd_back: got %b/%h expected 1/deadbeef", bus.dm_rvalid, bus.dm_rdata); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_wait();
        logic       got;
        logic [7:0] ctl;
        int         nvalid;
        issue_dm(1'b0, 64'h200, 64'h0, got);
        checks++; if ({got, bus.mem_en} !== 2'b11) begin errors++; $display("FAIL rst_pre_gnt: got gnt/mem_en %b expected 11", {got, bus.mem_en}); end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        ctl = {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid,
               bus.if_err, bus.dm_err, bus.mem_en, bus.mem_we};
        checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL rst_async_ctl: got %b expected 00000000", ctl); end
        checks++; if ({bus.dm_rdata, bus.mem_addr} !== 128'h0) begin errors++; $display("FAIL rst_async_data: got %h/%h expected 0/0", bus.dm_rdata, bus.mem_addr); end
        @(negedge clock) reset_n = 1'b1;
        nvalid = 0;
        repeat (8) begin
            @(negedge clock);
            if (bus.if_rvalid || bus.dm_rvalid) nvalid++;
        end
        checks++; if (nvalid !== 0) begin errors++; $display("FAIL rst_no_rvalid: got %0d rvalids expected 0", nvalid); end
        issue_if(64'h10, got);
        checks++; if ({got, bus.mem_en} !== 2'b11) begin errors++; $display("FAIL rst_post_gnt: got gnt/mem_en %b expected 11", {got, bus.mem_en}); end
        repeat (3) @(negedge clock);
        checks++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, D10}) begin errors++; $display("FAIL rst_post_resp: got %b/%h expected 1/%h", bus.if_rvalid, bus.if_rdata, D10); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_addr_error();
        test_write_read();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
